// File: rtl/rgb_pwm_pkg.sv
// Shared address map, CTRL bit positions and duty clamp for the RGB PWM controller.
// Optional build macro: RGB_PWM_FADE_EN (ramped duty changes).
package rgb_pwm_pkg;
    localparam logic [7:0] ADDR_CTRL      = 8'h00;
    localparam logic [7:0] ADDR_PRESCALE  = 8'h01;
    localparam logic [7:0] ADDR_STATUS    = 8'h02;
    localparam logic [7:0] ADDR_DUTY_BASE = 8'h10;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_CURREN = 1;

    // Anything above a full period of high time is meaningless, so clamp to 2**pwm_width.
    function automatic logic [31:0] sat_duty(input logic [31:0] value, input int pwm_width);
        logic [31:0] full;
        full = 32'd1 << pwm_width;
        return (value > full) ? full : value;
    endfunction
endpackage

// File: rtl/rgb_pwm_if.sv
// Core-bus register port of the RGB PWM controller; ready/read_data are registered by the slave.
// Optional build macro: RGB_PWM_FADE_EN (no effect on this interface).
interface rgb_pwm_if;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output cs, we, address, write_data, input read_data, ready);
    modport slave  (input cs, we, address, write_data, output read_data, ready);
endinterface

// File: rtl/rgb_pwm_channel.sv
// One PWM channel: duty register, period-boundary shadow (or fade ramp), compare and output flop.
// Optional build macro: RGB_PWM_FADE_EN steps the active duty by one per period.
module rgb_pwm_channel #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 duty_we,
    input  logic [PWM_WIDTH:0]   duty_wdata,
    input  logic                 boundary,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    output logic [PWM_WIDTH:0]   duty,
    output logic                 fading,
    output logic                 pwm
);
    logic [PWM_WIDTH:0] act_duty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     duty <= '0;
        else if (duty_we) duty <= duty_wdata;
    end

`ifdef RGB_PWM_FADE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_duty <= '0;
        end else if (!enable) begin
            act_duty <= duty;
        end else if (boundary) begin
            if (act_duty < duty)      act_duty <= act_duty + 1'b1;
            else if (act_duty > duty) act_duty <= act_duty - 1'b1;
        end
    end

    assign fading = (act_duty != duty);
`else
    // The boundary edge samples the old duty, so a same-edge write lands next period.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                 act_duty <= '0;
        else if (!enable || boundary) act_duty <= duty;
    end

    assign fading = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pwm <= 1'b0;
        else          pwm <= enable && ({1'b0, pwm_cnt} < act_duty);
    end
endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Register-mapped multi-channel PWM controller for the iCE40 RGB LED driver.
// Optional build macro: RGB_PWM_FADE_EN (see rgb_pwm_channel).
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int PWM_WIDTH = 8,
    parameter int PRE_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    rgb_pwm_if.slave          bus,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              led_en,
    output logic              curr_en
);
    localparam int DW = PWM_WIDTH + 1;

    logic [PRE_WIDTH-1:0] prescale;
    logic [PRE_WIDTH-1:0] pre_cnt;
    logic [PWM_WIDTH-1:0] pwm_cnt;
    logic                 wr;
    logic                 tick;
    logic                 boundary;
    logic [PWM_WIDTH:0]   duty_wdata;
    logic [NUM_CH-1:0]    duty_we;
    logic [NUM_CH-1:0]    fading;
    logic [PWM_WIDTH:0]   duty [NUM_CH];
    logic [31:0]          rd_mux;

    assign wr         = bus.cs && bus.we;
    assign tick       = led_en && (pre_cnt == prescale);
    assign boundary   = tick && (pwm_cnt == '1);
    assign duty_wdata = DW'(sat_duty(bus.write_data, PWM_WIDTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_en   <= 1'b0;
            curr_en  <= 1'b0;
            prescale <= '0;
        end else if (wr) begin
            if (bus.address == ADDR_CTRL) begin
                led_en  <= bus.write_data[CTRL_ENABLE];
                curr_en <= bus.write_data[CTRL_CURREN];
            end
            if (bus.address == ADDR_PRESCALE) prescale <= bus.write_data[PRE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else if (!led_en) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (wr && bus.address == ADDR_PRESCALE) pre_cnt <= '0;
            else if (tick)                          pre_cnt <= '0;
            else                                    pre_cnt <= pre_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign duty_we[i] = wr && (bus.address == ADDR_DUTY_BASE + 8'(i));

        rgb_pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .enable     (led_en),
            .duty_we    (duty_we[i]),
            .duty_wdata (duty_wdata),
            .boundary   (boundary),
            .pwm_cnt    (pwm_cnt),
            .duty       (duty[i]),
            .fading     (fading[i]),
            .pwm        (pwm_out[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        if (bus.address == ADDR_CTRL) begin
            rd_mux[CTRL_ENABLE] = led_en;
            rd_mux[CTRL_CURREN] = curr_en;
        end else if (bus.address == ADDR_PRESCALE) begin
            rd_mux[PRE_WIDTH-1:0] = prescale;
        end else if (bus.address == ADDR_STATUS) begin
            rd_mux[0]              = |fading;
            rd_mux[PWM_WIDTH+15:16] = pwm_cnt;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.address == ADDR_DUTY_BASE + 8'(i)) rd_mux[PWM_WIDTH:0] = duty[i];
            end
        end
    end

    // read_data holds the last read until the next read access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.ready     <= 1'b0;
            bus.read_data <= '0;
        end else begin
            bus.ready <= bus.cs;
            if (bus.cs && !bus.we) bus.read_data <= rd_mux;
        end
    end
endmodule
